// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared constants and parameter check for pipe_adder
// Purpose: operation mode encodings and the WIDTH/CHUNK legality check.
// Contents:
//   MODE_ADD, MODE_SUB : values of the sub input
//   width_ok()         : 1 when width is a positive multiple of chunk
package pipe_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic bit width_ok(input int width, input int chunk);
    return (chunk > 0) && (width > 0) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// rtl/pipe_adder_stage.sv - one CHUNK-bit slice of the pipelined adder
// Purpose: registered CHUNK-bit add of one operand slice plus incoming carry.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   hold             : 1 freezes every register in the stage
//   valid_in         : valid bit travelling with the operation
//   a_slice, b_slice : operand slices for this stage (b already inverted for sub)
//   carry_in         : carry from the previous stage (or sub for stage 0)
//   sum              : registered CHUNK-bit result slice
//   carry_out        : registered carry into the next stage
//   valid_out        : registered valid bit
module pipe_adder_stage #(
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             valid_in,
  input  logic [CHUNK-1:0] a_slice,
  input  logic [CHUNK-1:0] b_slice,
  input  logic             carry_in,
  output logic [CHUNK-1:0] sum,
  output logic             carry_out,
  output logic             valid_out
);

  logic [CHUNK:0] total;

  assign total = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      carry_out <= 1'b0;
      valid_out <= 1'b0;
    end else if (!hold) begin
      sum       <= total[CHUNK-1:0];
      carry_out <= total[CHUNK];
      valid_out <= valid_in;
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined WIDTH-bit adder/subtractor, CHUNK bits per stage
// Purpose: full-throughput add/sub with carry rippling through register stages.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : a/b/sub presented this cycle (accepted only when hold=0)
//   a, b       : unsigned operands
//   sub        : MODE_ADD -> a+b, MODE_SUB -> a+~b+1
//   hold       : freeze the whole pipeline and the result counter
//   out_valid  : c holds a completed result
//   c          : WIDTH+1-bit result, c[WIDTH] is carry-out (no-borrow for sub)
//   res_count  : results emitted since reset, saturating
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CHUNK = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             hold,
  output logic             out_valid,
  output logic [WIDTH:0]   c,
  output logic [CNT_W-1:0] res_count
);

  localparam int STAGES = WIDTH / CHUNK;

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
    $error("pipe_adder: WIDTH must be a positive multiple of CHUNK");
  end

  logic [WIDTH-1:0]  b_eff;
  logic [STAGES-1:0] carry;
  logic [STAGES-1:0] vld;
  logic [CHUNK-1:0]  sum [STAGES];
  logic [WIDTH-1:0]  c_data;

  assign b_eff = (sub == MODE_SUB) ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] a_k;
    logic [CHUNK-1:0] b_k;
    logic             cin_k;
    logic             vin_k;

    if (k == 0) begin : g_first
      assign a_k   = a[CHUNK-1:0];
      assign b_k   = b_eff[CHUNK-1:0];
      assign cin_k = sub;
      assign vin_k = in_valid;
    end else begin : g_skew
      // Slice k waits k cycles so it meets the carry of its own operation.
      logic [2*CHUNK-1:0] sr [k];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < k; i++) sr[i] <= '0;
        end else if (!hold) begin
          sr[0] <= {a[k*CHUNK +: CHUNK], b_eff[k*CHUNK +: CHUNK]};
          for (int i = 1; i < k; i++) sr[i] <= sr[i-1];
        end
      end
      assign {a_k, b_k} = sr[k-1];
      assign cin_k      = carry[k-1];
      assign vin_k      = vld[k-1];
    end

    pipe_adder_stage #(
      .CHUNK(CHUNK)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .hold      (hold),
      .valid_in  (vin_k),
      .a_slice   (a_k),
      .b_slice   (b_k),
      .carry_in  (cin_k),
      .sum       (sum[k]),
      .carry_out (carry[k]),
      .valid_out (vld[k])
    );

    // Early result slices wait until the last stage finishes the operation.
    if (k == STAGES - 1) begin : g_last
      assign c_data[k*CHUNK +: CHUNK] = sum[k];
    end else begin : g_deskew
      localparam int D = STAGES - 1 - k;
      logic [CHUNK-1:0] ds [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < D; i++) ds[i] <= '0;
        end else if (!hold) begin
          ds[0] <= sum[k];
          for (int i = 1; i < D; i++) ds[i] <= ds[i-1];
        end
      end
      assign c_data[k*CHUNK +: CHUNK] = ds[D-1];
    end
  end

  assign c         = {carry[STAGES-1], c_data};
  assign out_valid = vld[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_count <= '0;
    end else if (out_valid && !hold && (res_count != {CNT_W{1'b1}})) begin
      res_count <= res_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - directed self-checking bench for pipe_adder
module tb_pipe_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        sub;
  logic        hold;
  logic        out_valid;
  logic [4:0]  c;
  logic [15:0] res_count;
  logic        out_valid2;
  logic [4:0]  c2;
  logic [1:0]  res_count2;

  int checks = 0;
  int errors = 0;

  pipe_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .hold      (hold),
    .out_valid (out_valid),
    .c         (c),
    .res_count (res_count)
  );

  pipe_adder #(.WIDTH(4), .CHUNK(2), .CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .hold      (hold),
    .out_valid (out_valid2),
    .c         (c2),
    .res_count (res_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv, input logic s);
    in_valid = v;
    a        = av;
    b        = bv;
    sub      = s;
  endtask

  logic [3:0] va [4];
  logic [3:0] vb [4];
  logic [4:0] vexp [4];

  initial begin
    va = '{4'd1, 4'd2, 4'd3, 4'd7};
    vb = '{4'd1, 4'd2, 4'd3, 4'd8};
    vexp = '{5'd2, 5'd4, 5'd6, 5'd15};

    rst_n = 1'b1;
    hold  = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_c", c, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", res_count, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // 5 + 4, single op
    drive(1'b1, 4'd5, 4'd4, 1'b0);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    check("lat_early_valid", out_valid, 0);
    tick();
    check("add_5_4_c", c, 9);
    check("add_5_4_valid", out_valid, 1);
    tick();
    check("add_5_4_valid_once", out_valid, 0);
    check("add_5_4_count", res_count, 1);

    // 15+15, 4-5, 5-4 back to back
    drive(1'b1, 4'd15, 4'd15, 1'b0);
    tick();
    drive(1'b1, 4'd4, 4'd5, 1'b1);
    tick();
    check("add_15_15_c", c, 5'b11110);
    check("add_15_15_valid", out_valid, 1);
    drive(1'b1, 4'd5, 4'd4, 1'b1);
    tick();
    check("sub_4_5_c", c, 5'b01111);
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    check("sub_5_4_c", c, 5'b10001);
    tick();
    check("mix_valid_end", out_valid, 0);
    check("mix_count", res_count, 4);

    // four back-to-back adds
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, va[i], vb[i], 1'b0);
      else       drive(1'b0, 4'd0, 4'd0, 1'b0);
      tick();
      if (i >= 1 && i <= 4) begin
        check($sformatf("b2b_c_%0d", i - 1), c, vexp[i-1]);
        check($sformatf("b2b_valid_%0d", i - 1), out_valid, 1);
      end
    end
    check("b2b_valid_end", out_valid, 0);
    check("b2b_count", res_count, 8);
    check("sat_count", res_count2, 3);

    // hold with two ops in flight; input during hold is dropped
    drive(1'b1, 4'd1, 4'd2, 1'b0);
    tick();
    drive(1'b1, 4'd6, 4'd7, 1'b0);
    tick();
    check("hold_pre_c", c, 3);
    drive(1'b1, 4'd9, 4'd9, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_c_%0d", i), c, 3);
      check($sformatf("hold_valid_%0d", i), out_valid, 1);
      check($sformatf("hold_count_%0d", i), res_count, 8);
    end
    hold = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    check("hold_post_c", c, 13);
    check("hold_post_valid", out_valid, 1);
    check("hold_post_count", res_count, 9);
    tick();
    check("hold_drop_valid_a", out_valid, 0);
    tick();
    check("hold_drop_valid_b", out_valid, 0);
    check("hold_final_count", res_count, 10);
    check("sat_after_hold", res_count2, 3);
    check("sat_still_emits", out_valid2, 0);

    // reset with two ops in flight
    drive(1'b1, 4'd2, 4'd3, 1'b0);
    tick();
    drive(1'b1, 4'd4, 4'd4, 1'b0);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", res_count, 0);
    check("mid_rst_c", c, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_valid_%0d", i), out_valid, 0);
    end
    check("post_rst_count", res_count, 0);
    drive(1'b1, 4'd5, 4'd4, 1'b0);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    check("post_rst_c", c, 9);
    check("post_rst_op_valid", out_valid, 1);
    tick();
    check("post_rst_op_count", res_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
